// File: rtl/skew_feeder.sv
// Skew feeder: turns one activation vector per cycle into a diagonal wavefront
// for the left edge of an N-row systolic array. Row r is delayed r+1 cycles.
module skew_feeder #(
    parameter int N      = 4,
    parameter int MUL_BW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [N*MUL_BW-1:0]   i_data,
    input  logic                  i_last,
    output logic                  o_ready,
    output logic [N*MUL_BW-1:0]   o_left,
    output logic [N-1:0]          o_row_valid,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    localparam int CW = $clog2(N);

    state_t        state;
    logic [CW-1:0] drain_cnt;
    logic          accept;

    // Readiness is withheld during reset so nothing is accepted on a reset edge.
    assign o_ready = rst && (state != DRAIN);
    assign accept  = i_valid && o_ready;
    assign o_busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE, STREAM: begin
                    if (accept) begin
                        if (i_last) begin
                            state     <= DRAIN;
                            drain_cnt <= CW'(N - 1);
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state  <= IDLE;
                        o_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Each row owns a private chain of r+1 stages feeding a final output register.
    for (genvar r = 0; r < N; r++) begin : g_row
        logic [MUL_BW-1:0] stage_d [r+1];
        logic [r:0]        stage_v;
        logic [MUL_BW-1:0] out_d;
        logic              out_v;

        always_ff @(posedge clk) begin
            // NOTE: the chain registers are a small shift memory, but they are
            // reset anyway so a reset truly discards in-flight activations.
            if (!rst) begin
                for (int k = 0; k <= r; k++) begin
                    stage_d[k] <= '0;
                end
                stage_v <= '0;
                out_d   <= '0;
                out_v   <= 1'b0;
            end else begin
                stage_d[0] <= accept ? i_data[r*MUL_BW +: MUL_BW] : '0;
                stage_v[0] <= accept;
                for (int k = 1; k <= r; k++) begin
                    stage_d[k] <= stage_d[k-1];
                    stage_v[k] <= stage_v[k-1];
                end
                out_d <= stage_d[r];
                out_v <= stage_v[r];
            end
        end

        assign o_left[r*MUL_BW +: MUL_BW] = out_d;
        assign o_row_valid[r]             = out_v;
    end

endmodule

// File: tb/tb_skew_feeder.sv
// Directed plus randomized bench for skew_feeder; expected outputs come from an
// edge-indexed injection history and a drain-window model of the handshake.
module tb_skew_feeder;

    localparam int N      = 4;
    localparam int MUL_BW = 16;
    localparam int W      = N * MUL_BW;
    localparam int MAXE   = 4096;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_valid;
    logic [W-1:0]   i_data;
    logic           i_last;
    logic           o_ready;
    logic [W-1:0]   o_left;
    logic [N-1:0]   o_row_valid;
    logic           o_busy;
    logic           o_done;

    skew_feeder #(.N(N), .MUL_BW(MUL_BW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_last      (i_last),
        .o_ready     (o_ready),
        .o_left      (o_left),
        .o_row_valid (o_row_valid),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    // Reference model state: what entered the skew lines at each edge.
    logic [W-1:0] hist_d [MAXE];
    logic [N-1:0] hist_v [MAXE];
    int           t;              // number of rising edges so far
    int           last_rst_edge;  // history at or before this edge is wiped
    int           done_edge;      // edge after which o_done is expected, -1 none
    bit           streaming;
    int           n_cmp;
    int           n_err;

    function automatic bit draining();
        return (done_edge >= 0) && (t < done_edge);
    endfunction

    task automatic cmp(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    // One clock cycle: drive, check ready, clock, update model, check outputs.
    task automatic step(input bit v, input bit l, input logic [W-1:0] d, input bit rv);
        bit           exp_ready;
        bit           acc;
        logic [W-1:0] exp_left;
        logic [N-1:0] exp_rv;
        int           a;
        @(negedge clk);
        i_valid = v;
        i_last  = l;
        i_data  = d;
        rst     = rv;
        #1;
        exp_ready = rv && !draining();
        cmp("ready", W'(o_ready), W'(exp_ready));
        acc = v && exp_ready;

        @(posedge clk);
        t++;
        if (!rv) begin
            last_rst_edge = t;
            streaming     = 1'b0;
            done_edge     = -1;
        end else begin
            hist_d[t] = acc ? d : '0;
            hist_v[t] = acc ? '1 : '0;
            if (acc) begin
                if (l) begin
                    streaming = 1'b0;
                    done_edge = t + N;
                end else begin
                    streaming = 1'b1;
                end
            end
        end

        // A value that entered at edge a shows on slice r after edge a+1+r.
        exp_left = '0;
        exp_rv   = '0;
        for (int r = 0; r < N; r++) begin
            a = t - 1 - r;
            if (a > last_rst_edge) begin
                exp_left[r*MUL_BW +: MUL_BW] = hist_d[a][r*MUL_BW +: MUL_BW];
                exp_rv[r]                    = hist_v[a][r];
            end
        end
        #1;
        cmp("left",      o_left,           exp_left);
        cmp("row_valid", W'(o_row_valid),  W'(exp_rv));
        cmp("done",      W'(o_done),       W'(t == done_edge));
        cmp("busy",      W'(o_busy),       W'(streaming || draining()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b1);
    endtask

    function automatic logic [W-1:0] rnd_vec();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        logic [W-1:0] v0;
        logic [W-1:0] held;
        t             = 0;
        last_rst_edge = 0;
        done_edge     = -1;
        streaming     = 1'b0;
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b0;
        i_valid       = 1'b0;
        i_last        = 1'b0;
        i_data        = '0;

        // Reset, including an attempted accept while reset is held.
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, rnd_vec(), 1'b0);
        idle(2);

        // Single vector with i_last: diagonal wavefront, then done.
        step(1'b1, 1'b1, 64'h4040_4000_3F80_3F00, 1'b1);
        idle(6);

        // Three back-to-back vectors, last flagged on the third.
        step(1'b1, 1'b0, rnd_vec(), 1'b1);
        step(1'b1, 1'b0, rnd_vec(), 1'b1);
        step(1'b1, 1'b1, rnd_vec(), 1'b1);
        idle(6);

        // Bubble between two vectors.
        step(1'b1, 1'b0, rnd_vec(), 1'b1);
        idle(1);
        step(1'b1, 1'b1, rnd_vec(), 1'b1);
        idle(6);

        // Backpressure: valid held through drain until accepted.
        step(1'b1, 1'b1, rnd_vec(), 1'b1);
        held = rnd_vec();
        for (int i = 0; i < N + 1; i++) step(1'b1, 1'b1, held, 1'b1);
        idle(6);

        // Reset in the middle of a stream and in the middle of a drain.
        step(1'b1, 1'b0, rnd_vec(), 1'b1);
        step(1'b1, 1'b0, rnd_vec(), 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);
        idle(6);
        step(1'b1, 1'b1, rnd_vec(), 1'b1);
        idle(2);
        step(1'b0, 1'b0, '0, 1'b0);
        idle(6);

        // Stray i_last without i_valid.
        step(1'b0, 1'b1, rnd_vec(), 1'b1);
        step(1'b0, 1'b1, rnd_vec(), 1'b1);
        idle(2);

        // Bit-exact pass-through of extreme patterns.
        v0 = '1;
        step(1'b1, 1'b0, v0, 1'b1);
        step(1'b1, 1'b1, 64'h8000_7F80_FF80_0001, 1'b1);
        idle(6);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, ($urandom % 6) == 0, rnd_vec(), ($urandom % 50) != 0);
        end
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
